cv32e40p_mult_ft_ctrl: RTL and testbench

- Sequencing and fault-management controller for the triplicated (TMR) multiplier in the EX stage.
- Issues each multiply to the triplicated core and watches the per-replica disagreement flags at completion.
- Single-replica faults are masked and logged. Uncorrectable disagreements are retried. Replicas that fail repeatedly are marked permanently faulty.
- Sits between the EX-stage issue logic and the multiplier enable/ready signals.

---
 rtl/cv32e40p_mult_ft_ctrl.sv | 164 ++++++++++++++++
 tb/tb_cv32e40p_mult_ft_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_mult_ft_ctrl.sv
// Sequencing and fault-management controller for the triplicated EX-stage multiplier.
// Issues operations to the TMR core, evaluates replica disagreement at completion,
// masks single-replica faults, retries uncorrectable results and retires replicas
// that keep disagreeing.
module cv32e40p_mult_ft_ctrl #(
    parameter int unsigned MAX_RETRY   = 2,
    parameter int unsigned PERM_THRESH = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    output logic             mult_en_o,
    input  logic             mult_ready_i,
    input  logic [2:0]       disagree_i,
    output logic             done_o,
    output logic             err_o,
    output logic [2:0]       replica_fail_o,
    output logic [CNT_W-1:0] fault_cnt_o,
    input  logic             err_clear_i
);

    localparam int unsigned RCW = (PERM_THRESH < 1) ? 1 : $clog2(PERM_THRESH + 1);
    localparam int unsigned RTW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RCW-1:0] THRESH    = RCW'(PERM_THRESH);
    localparam logic [RTW-1:0] RETRY_MAX = RTW'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        RETRY = 2'd2,
        ERROR = 2'd3
    } state_e;

    state_e           state_q;
    logic             op_ready_q;
    logic             mult_en_q;
    logic             done_q;
    logic             err_q;
    logic [RTW-1:0]   retry_cnt_q;
    logic [CNT_W-1:0] fault_cnt_q;
    logic [CNT_W-1:0] fault_cnt_d;
    logic [2:0]       rep_fail_q;
    logic [2:0]       rep_fail_d;
    logic [RCW-1:0]   rep_cnt_q [3];
    logic [RCW-1:0]   rep_cnt_d [3];

    logic             eval;
    logic [2:0]       eff_dis;
    logic [2:0]       unusable;
    logic             correctable;

    function automatic logic [1:0] popcnt3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // Evaluate the completing operation: failed replicas are ignored, and the vote is
    // still trustworthy as long as no more than one replica is out of the picture.
    always_comb begin
        eval        = (state_q == EXEC) && mult_ready_i;
        eff_dis     = disagree_i & ~rep_fail_q;
        unusable    = rep_fail_q | eff_dis;
        correctable = (popcnt3(eff_dis) <= 2'd1) && (popcnt3(unusable) <= 2'd1);
    end

    // Next-state of the fault bookkeeping: total event counter and per-replica streaks.
    always_comb begin
        fault_cnt_d = fault_cnt_q;
        rep_fail_d  = rep_fail_q;
        rep_cnt_d   = rep_cnt_q;
        if (eval && (disagree_i != 3'b000) && (fault_cnt_q != {CNT_W{1'b1}})) begin
            fault_cnt_d = fault_cnt_q + 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            if (eval && !rep_fail_q[i]) begin
                if (eff_dis[i]) begin
                    if (rep_cnt_q[i] != THRESH) begin
                        rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
                    end
                    if ((rep_cnt_q[i] + 1'b1) >= THRESH) begin
                        rep_fail_d[i] = 1'b1;
                    end
                end else begin
                    rep_cnt_d[i] = '0;
                end
            end
        end
    end

    // Main sequencer with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_ready_q  <= 1'b1;
            mult_en_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            retry_cnt_q <= '0;
            fault_cnt_q <= '0;
            rep_fail_q  <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                rep_cnt_q[i] <= '0;
            end
        end else begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            fault_cnt_q <= fault_cnt_d;
            rep_fail_q  <= rep_fail_d;
            rep_cnt_q   <= rep_cnt_d;
            case (state_q)
                IDLE: begin
                    if (op_valid_i && op_ready_q) begin
                        state_q     <= EXEC;
                        retry_cnt_q <= '0;
                        op_ready_q  <= 1'b0;
                        mult_en_q   <= 1'b1;
                    end else begin
                        op_ready_q  <= 1'b1;
                    end
                end
                EXEC: begin
                    if (mult_ready_i) begin
                        mult_en_q <= 1'b0;
                        if (correctable) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else if (retry_cnt_q < RETRY_MAX) begin
                            state_q <= RETRY;
                        end else begin
                            state_q <= ERROR;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                RETRY: begin
                    retry_cnt_q <= retry_cnt_q + 1'b1;
                    state_q     <= EXEC;
                    mult_en_q   <= 1'b1;
                end
                ERROR: begin
                    if (err_clear_i) begin
                        state_q    <= IDLE;
                        op_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    op_ready_q <= 1'b1;
                    mult_en_q  <= 1'b0;
                end
            endcase
        end
    end

    assign op_ready_o     = op_ready_q;
    assign mult_en_o      = mult_en_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign replica_fail_o = rep_fail_q;
    assign fault_cnt_o    = fault_cnt_q;

endmodule

// File: tb/tb_cv32e40p_mult_ft_ctrl.sv
// Self-checking bench for the TMR multiplier fault controller: a reference model of
// the fault bookkeeping feeds a scoreboard of expected completions.
module tb_cv32e40p_mult_ft_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid_i;
    logic        op_ready_o;
    logic        mult_en_o;
    logic        mult_ready_i;
    logic [2:0]  disagree_i;
    logic        done_o;
    logic        err_o;
    logic [2:0]  replica_fail_o;
    logic [15:0] fault_cnt_o;
    logic        err_clear_i;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        err;
        logic [15:0] fault;
        logic [2:0]  fail;
    } exp_t;

    exp_t sb[$];

    logic [2:0] m_fail;
    int         m_cnt [3];
    int         m_fault;

    cv32e40p_mult_ft_ctrl #(
        .MAX_RETRY(2),
        .PERM_THRESH(4),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .op_valid_i(op_valid_i),
        .op_ready_o(op_ready_o),
        .mult_en_o(mult_en_o),
        .mult_ready_i(mult_ready_i),
        .disagree_i(disagree_i),
        .done_o(done_o),
        .err_o(err_o),
        .replica_fail_o(replica_fail_o),
        .fault_cnt_o(fault_cnt_o),
        .err_clear_i(err_clear_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_fail  = 3'b000;
        m_fault = 0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        sb.delete();
    endtask

    // Returns 0 = correctable, 1 = retry, 2 = error; updates the reference fault state.
    function automatic int model_eval(input logic [2:0] dis, input int retry);
        logic [2:0] eff;
        logic [2:0] unus;
        bit         ok;
        eff  = dis & ~m_fail;
        unus = m_fail | eff;
        ok   = ($countones(eff) <= 1) && ($countones(unus) <= 1);
        if (dis != 3'b000 && m_fault < 65535) m_fault++;
        for (int i = 0; i < 3; i++) begin
            if (!m_fail[i]) begin
                if (eff[i]) begin
                    m_cnt[i]++;
                    if (m_cnt[i] >= 4) m_fail[i] = 1'b1;
                end else begin
                    m_cnt[i] = 0;
                end
            end
        end
        if (ok) return 0;
        return (retry < 2) ? 1 : 2;
    endfunction

    task automatic applyStimulus(input logic [2:0] d0, input logic [2:0] d1,
                                 input logic [2:0] d2, input int lat);
        logic [2:0] dl [3];
        int         guard;
        int         res;
        exp_t       e;
        dl[0] = d0; dl[1] = d1; dl[2] = d2;
        guard = 0;
        while (op_ready_o !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 50) begin
            failures++;
            $display("[TB] FAIL ready_timeout actual=%b required=1", op_ready_o);
            return;
        end
        op_valid_i = 1'b1;
        tick();
        op_valid_i = 1'b0;
        checks++;
        if (mult_en_o !== 1'b1 || op_ready_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL issue actual en=%b rdy=%b required en=1 rdy=0", mult_en_o, op_ready_o);
        end
        res = 1;
        for (int k = 0; k < 3 && res == 1; k++) begin
            repeat (lat) tick();
            mult_ready_i = 1'b1;
            disagree_i   = dl[k];
            res = model_eval(dl[k], k);
            if (res != 1) begin
                e.err = (res == 2); e.fault = 16'(m_fault); e.fail = m_fail;
                sb.push_back(e);
            end
            tick();
            mult_ready_i = 1'b0;
            disagree_i   = 3'b000;
            if (res == 1) begin
                checks++;
                if (mult_en_o !== 1'b0 || done_o !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL retry_gap actual en=%b done=%b required en=0 done=0", mult_en_o, done_o);
                end
                tick();
                checks++;
                if (mult_en_o !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL retry_reissue actual en=%b required en=1", mult_en_o);
                end
            end
        end
        checkOutput();
    endtask

    task automatic checkOutput();
        int   guard;
        exp_t e;
        guard = 0;
        while (done_o !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 20 || sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL done_timeout actual done=%b pending=%0d required done=1", done_o, sb.size());
            return;
        end
        e = sb.pop_front();
        checks++;
        if (err_o !== e.err || fault_cnt_o !== e.fault || replica_fail_o !== e.fail) begin
            failures++;
            $display("[TB] FAIL done_result actual err=%b cnt=%0d fail=%b required err=%b cnt=%0d fail=%b",
                     err_o, fault_cnt_o, replica_fail_o, e.err, e.fault, e.fail);
        end
        checks++;
        if (op_ready_o !== 1'b0 || mult_en_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_cycle actual rdy=%b en=%b required rdy=0 en=0", op_ready_o, mult_en_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0 || op_ready_o !== !e.err) begin
            failures++;
            $display("[TB] FAIL after_done actual done=%b rdy=%b required done=0 rdy=%b", done_o, op_ready_o, !e.err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
        checks++;
        if (op_ready_o !== 1'b1 || mult_en_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 ||
            replica_fail_o !== 3'b000 || fault_cnt_o !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_state actual rdy=%b en=%b done=%b err=%b fail=%b cnt=%0d required 1 0 0 0 000 0",
                     op_ready_o, mult_en_o, done_o, err_o, replica_fail_o, fault_cnt_o);
        end
    endtask

    task automatic test_clean();
        applyStimulus(3'b000, 3'b000, 3'b000, 1);
        applyStimulus(3'b000, 3'b000, 3'b000, 0);
    endtask

    task automatic test_masked_fault();
        test_reset();
        for (int i = 0; i < 5; i++) applyStimulus(3'b010, 3'b000, 3'b000, 1);
    endtask

    task automatic test_consecutive_clear();
        test_reset();
        for (int i = 0; i < 3; i++) applyStimulus(3'b001, 3'b000, 3'b000, 2);
        applyStimulus(3'b000, 3'b000, 3'b000, 1);
        applyStimulus(3'b001, 3'b000, 3'b000, 1);
    endtask

    task automatic test_retry();
        test_reset();
        applyStimulus(3'b111, 3'b000, 3'b000, 1);
        test_reset();
        applyStimulus(3'b111, 3'b111, 3'b111, 1);
        op_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (op_ready_o !== 1'b0 || mult_en_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL error_hold actual rdy=%b en=%b required rdy=0 en=0", op_ready_o, mult_en_o);
            end
        end
        err_clear_i = 1'b1;
        tick();
        err_clear_i = 1'b0;
        op_valid_i  = 1'b0;
        checks++;
        if (op_ready_o !== 1'b1 || mult_en_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL error_clear actual rdy=%b en=%b required rdy=1 en=0", op_ready_o, mult_en_o);
        end
        tick();
        applyStimulus(3'b000, 3'b000, 3'b000, 1);
    endtask

    task automatic test_degraded();
        test_reset();
        for (int i = 0; i < 4; i++) applyStimulus(3'b100, 3'b000, 3'b000, 1);
        applyStimulus(3'b001, 3'b000, 3'b000, 1);
        applyStimulus(3'b100, 3'b000, 3'b000, 1);
    endtask

    task automatic test_reset_mid_exec();
        test_reset();
        for (int i = 0; i < 4; i++) applyStimulus(3'b010, 3'b000, 3'b000, 0);
        op_valid_i = 1'b1;
        tick();
        op_valid_i = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        checks++;
        if (op_ready_o !== 1'b1 || mult_en_o !== 1'b0 || done_o !== 1'b0 ||
            replica_fail_o !== 3'b000 || fault_cnt_o !== 16'd0) begin
            failures++;
            $display("[TB] FAIL mid_exec_reset actual rdy=%b en=%b done=%b fail=%b cnt=%0d required 1 0 0 000 0",
                     op_ready_o, mult_en_o, done_o, replica_fail_o, fault_cnt_o);
        end
        mult_ready_i = 1'b1;
        tick();
        mult_ready_i = 1'b0;
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL no_done_after_reset actual done=%b required 0", done_o);
        end
        applyStimulus(3'b000, 3'b000, 3'b000, 1);
    endtask

    task automatic test_back_to_back();
        applyStimulus(3'b001, 3'b000, 3'b000, 0);
        applyStimulus(3'b000, 3'b000, 3'b000, 0);
        applyStimulus(3'b011, 3'b000, 3'b000, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        op_valid_i   = 1'b0;
        mult_ready_i = 1'b0;
        disagree_i   = 3'b000;
        err_clear_i  = 1'b0;
        model_reset();
        test_reset();
        test_clean();
        test_masked_fault();
        test_consecutive_clear();
        test_retry();
        test_degraded();
        test_reset_mid_exec();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
